// File: rtl/decryption_pkg.sv
// Shared types and defaults for the toy-cipher decryption datapath.
// The optional range check is enabled by defining DECRYPTION_RANGE_CHECK_EN.
package decryption_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int P_PAR_DEF = 227;
  localparam logic [1:0] MODE_DECRYPT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB1 = 2'd1,
    SUB2 = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/decryption_mod_sub.sv
// Combinational modular subtractor: diff = (a - b) mod P_PAR.
// The result is valid for operands that are already reduced below P_PAR.
module mod_sub #(
  parameter int WIDTH = 8,
  parameter int P_PAR = 227
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(P_PAR);

  logic [WIDTH:0] d;

  always_comb begin
    d    = {1'b0, a} - {1'b0, b};
    // a borrow wraps the 9-bit difference; adding the modulus brings it back in range
    diff = (a < b) ? WIDTH'(d + MOD) : d[WIDTH-1:0];
  end
endmodule

// File: rtl/decryption.sv
// Decryption stage: P = (C2 - C1 - Sk) mod P_PAR over a shared subtractor.
// Defining DECRYPTION_RANGE_CHECK_EN adds operand range checking and drives err.
//
// state | meaning
// IDLE  | waiting for a ciphertext while mode selects decryption
// SUB1  | t = C2 - C1
// SUB2  | plaintext = t - Sk (or 0 on range error)
// DONE  | result presented until the consumer takes it
module decryption
  import decryption_pkg::*;
#(
  parameter int P_PAR = P_PAR_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cipher_c1,
  input  logic [WIDTH-1:0] cipher_c2,
  input  logic [WIDTH-1:0] secret_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] plaintext,
  output logic             err
);
  state_t           state;
  logic [WIDTH-1:0] c1_q;
  logic [WIDTH-1:0] c2_q;
  logic [WIDTH-1:0] sk_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_res;

  // rst_n is active-high; the port name is inherited from the surrounding datapath
  assign in_ready = !rst_n && (state == IDLE) && (mode == MODE_DECRYPT);

  always_comb begin
    sub_a = t_q;
    sub_b = sk_q;
    if (state == SUB1) begin
      sub_a = c2_q;
      sub_b = c1_q;
    end
  end

  mod_sub #(
    .WIDTH(WIDTH),
    .P_PAR(P_PAR)
  ) u_mod_sub (
    .a   (sub_a),
    .b   (sub_b),
    .diff(sub_res)
  );

`ifdef DECRYPTION_RANGE_CHECK_EN
  localparam logic [WIDTH:0] P_W = (WIDTH+1)'(P_PAR);

  logic err_q;
  logic err_r;
  logic range_bad;

  assign range_bad = ({1'b0, cipher_c1} >= P_W) || ({1'b0, cipher_c2} >= P_W) ||
                     (secret_key == '0) || ({1'b0, secret_key} >= P_W);
  assign err = err_r;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_q <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (in_valid && in_ready) err_q <= range_bad;
      if (state == SUB2) err_r <= err_q;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      c1_q      <= '0;
      c2_q      <= '0;
      sk_q      <= '0;
      t_q       <= '0;
      out_valid <= 1'b0;
      plaintext <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            c1_q  <= cipher_c1;
            c2_q  <= cipher_c2;
            sk_q  <= secret_key;
            state <= SUB1;
          end
        end
        SUB1: begin
          t_q   <= sub_res;
          state <= SUB2;
        end
        SUB2: begin
`ifdef DECRYPTION_RANGE_CHECK_EN
          plaintext <= err_q ? '0 : sub_res;
`else
          plaintext <= sub_res;
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decryption.sv
// Scoreboard bench for decryption: a driver pushes expected plaintexts computed
// from the cipher equations, and an independent monitor checks each presented result.
module tb_decryption;
  localparam int P = 227;
`ifdef DECRYPTION_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] cipher_c1 = '0;
  logic [7:0] cipher_c2 = '0;
  logic [7:0] secret_key = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] plaintext;
  logic       err;

  decryption dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_c1 (cipher_c1),
    .cipher_c2 (cipher_c2),
    .secret_key(secret_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int e;
    bit care;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ref_dec(input int c1, input int c2, input int sk);
    return ((c2 - c1 - sk) % P + P) % P;
  endfunction

  task automatic send(input int c1, input int c2, input int sk);
    exp_t e;
    int   budget;
    bit   bad;
    @(negedge clk);
    mode       = 2'b10;
    cipher_c1  = c1[7:0];
    cipher_c2  = c2[7:0];
    secret_key = sk[7:0];
    in_valid   = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 60) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("accept_in_time", int'(in_ready), 1);
    if (in_ready) begin
      bad    = (c1 >= P) || (c2 >= P) || (sk == 0) || (sk >= P);
      e.e    = (RC && bad) ? 1 : 0;
      e.p    = bad ? 0 : ref_dec(c1, c2, sk);
      e.care = !bad || RC;
      e.acc  = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // monitor: first sight of each result is popped from the scoreboard, then held stable
  initial begin
    bit   seen = 1'b0;
    bit   hs;
    exp_t e;
    int   held_p = 0;
    int   held_e = 0;
    forever begin
      @(posedge clk);
      hs = out_valid && out_ready && !rst_n;
      #1;
      if (hs || rst_n) seen = 1'b0;
      if (!rst_n && out_valid) begin
        if (!seen) begin
          chk("result_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", cyc - e.acc, 2);
            chk("err", int'(err), e.e);
            if (e.care) chk("plaintext", int'(plaintext), e.p);
          end
          held_p = int'(plaintext);
          held_e = int'(err);
          seen   = 1'b1;
        end else begin
          chk("hold_plaintext", int'(plaintext), held_p);
          chk("hold_err", int'(err), held_e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int budget;
    int sk, q, r, pt, pk, c1, c2;

    mode = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_plaintext", int'(plaintext), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    send(12, 122, 10);
    send(25, 28, 30);
    send(200, 10, 1);
    send(227, 5, 3);

    // mode gating
    @(negedge clk);
    mode     = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("gated_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    mode     = 2'b10;

    // back-pressure in DONE
    out_ready = 1'b0;
    send(12, 122, 10);
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("bp_reached_done", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_plaintext", int'(plaintext), 100);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("after_hs_out_valid", int'(out_valid), 0);
    chk("after_hs_in_ready", int'(in_ready), 1);

    // reset during SUB2
    send(25, 28, 30);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_plaintext", int'(plaintext), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("postrst_in_ready", int'(in_ready), 1);
    send(200, 10, 1);

    // randomized traffic from the encryption equations, with random back-pressure
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        c1 = $urandom_range(0, 255);
        c2 = $urandom_range(0, 255);
        sk = $urandom_range(0, 255);
      end else begin
        sk = $urandom_range(1, P - 1);
        q  = $urandom_range(0, P - 1);
        r  = $urandom_range(0, P - 1);
        pt = $urandom_range(0, P - 1);
        pk = (sk + q) % P;
        c1 = (q + r) % P;
        c2 = (pt + pk + r) % P;
      end
      send(c1, c2, sk);
    end
    bp_en     = 1'b0;
    out_ready = 1'b1;

    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
